// File: rtl/sf192_mpx_scheduler.sv
// sf192_mpx_scheduler: 192 kHz sample scheduler that fetches L/R pairs and publishes L+R / L-R.
// Optional underrun_cnt output is enabled by defining SF192_UNDERRUN_CNT_EN.
module sf192_mpx_scheduler #(
    parameter int CLK_DIV = 521,
    parameter int DW      = 18
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] left_in,
    input  logic [DW-1:0] right_in,
    output logic          sample_tick,
    output logic [DW:0]   sum_out,
    output logic [DW:0]   diff_out,
    output logic          out_valid,
    output logic          busy,
    output logic          underrun,
`ifdef SF192_UNDERRUN_CNT_EN
    output logic [15:0]   underrun_cnt,
`endif
    input  logic          underrun_clr
);
    typedef enum logic [2:0] {IDLE, FETCH, SUM, DIFF, PUBLISH} state_t;
    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
    state_t        state;
    logic [15:0]   count;
    logic [DW-1:0] l_reg, r_reg;
    logic [DW:0]   sum_reg, diff_reg;
    logic          urun_ev;
    // A tick seen while still waiting for the source is an underrun; a same-cycle handshake wins.
    assign urun_ev = (state == FETCH) && !in_valid && sample_tick;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= enable && (count == LAST);
            count       <= (!enable || count == LAST) ? '0 : count + 16'd1;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            l_reg     <= '0;
            r_reg     <= '0;
            sum_reg   <= '0;
            diff_reg  <= '0;
            sum_out   <= '0;
            diff_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (sample_tick) begin
                    state    <= FETCH;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                FETCH: if (in_valid) begin
                    l_reg    <= left_in;
                    r_reg    <= right_in;
                    state    <= SUM;
                    in_ready <= 1'b0;
                end else if (sample_tick) begin
                    state    <= SUM;
                    in_ready <= 1'b0;
                end
                SUM: begin
                    sum_reg <= {l_reg[DW-1], l_reg} + {r_reg[DW-1], r_reg};
                    state   <= DIFF;
                end
                DIFF: begin
                    diff_reg <= {l_reg[DW-1], l_reg} - {r_reg[DW-1], r_reg};
                    state    <= PUBLISH;
                end
                PUBLISH: begin
                    sum_out   <= sum_reg;
                    diff_out  <= diff_reg;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) underrun <= 1'b0;
        else underrun <= urun_ev ? 1'b1 : underrun_clr ? 1'b0 : underrun;
    end
`ifdef SF192_UNDERRUN_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) underrun_cnt <= '0;
        else if (urun_ev && underrun_clr) underrun_cnt <= 16'd1;
        else if (urun_ev) underrun_cnt <= (underrun_cnt == 16'hFFFF) ? underrun_cnt : underrun_cnt + 16'd1;
        else if (underrun_clr) underrun_cnt <= '0;
    end
`endif
endmodule

// File: doc/sf192_mpx_scheduler.md
Name: sf192_mpx_scheduler

Overview:
- Sample-rate controller for the 192 kHz stereo-multiplex datapath.
- Divides the system clock down to a 192 kHz sample tick and fetches one LEFT/RIGHT pair per tick from the audio source over a valid/ready handshake.
- Sequences the shared adder through the L+R and L-R phases, then publishes both results with a one-cycle valid strobe to the FM stage.
- Detects and flags source underruns, reusing the last sample when one occurs.

Parameters:
- CLK_DIV, 521, system clocks per sample tick (100 MHz / 192 kHz, rounded); legal range 8..65535.
- DW, 18, audio sample width, signed two's complement.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high runs the tick divider; low holds it at 0.
- in_valid  in  1  source has a LEFT/RIGHT pair available.
- in_ready  out  1  scheduler accepts a pair this cycle.
- left_in  in  DW  signed left sample.
- right_in  in  DW  signed right sample.
- sample_tick  out  1  one-cycle pulse at the 192 kHz rate.
- sum_out  out  DW+1  signed L+R, held between updates.
- diff_out  out  DW+1  signed L-R, held between updates.
- out_valid  out  1  one-cycle pulse when sum_out/diff_out update.
- busy  out  1  high whenever FSM is not in IDLE.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0; divider count 0; FSM to IDLE; captured L/R registers 0.
  - Assertion mid-frame aborts the frame; no out_valid is produced.
- Divider:
  - While enable=1, count runs 0..CLK_DIV-1 and wraps to 0.
  - sample_tick is registered and high for the one cycle following count==CLK_DIV-1.
  - enable=0: count forced to 0 and no ticks issue. A frame already in progress still completes.
- FSM states: IDLE, FETCH, SUM, DIFF, PUBLISH.
  - IDLE: on sample_tick go to FETCH.
  - FETCH: in_ready=1 (in_ready is low in every other state). On in_valid&in_ready, capture left_in/right_in and go to SUM.
  - FETCH, sample_tick with no handshake: set underrun, keep previous captured pair, go to SUM. That tick is consumed.
  - FETCH, sample_tick and in_valid high in the same cycle: the handshake wins; underrun is not set.
  - SUM: sum_reg <= sign-extended L + R; go to DIFF.
  - DIFF: diff_reg <= sign-extended L - R; go to PUBLISH.
  - PUBLISH: sum_out/diff_out <= sum_reg/diff_reg; out_valid=1 the next cycle; go to IDLE.
- Latency: handshake on edge k -> out_valid high and new outputs visible in the cycle after edge k+3.
- Arithmetic: DW+1 bits, so no overflow is possible; no saturation is needed.
- Timing guarantee: CLK_DIV>=8 ensures no tick can arrive in SUM, DIFF or PUBLISH.
- underrun:
  - Set by the underrun event; cleared by underrun_clr.
  - Set and clear in the same cycle: set wins.
- busy = (state != IDLE).

Optional Feature:
- Macro SF192_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt [15:0], reset 0.
  - Increments on each underrun event and saturates at 16'hFFFF.
  - Cleared by underrun_clr; a simultaneous event and clear yields 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check, CLK_DIV=8: hold reset low -> all outputs 0, in_ready=0, no sample_tick. Release with enable=1 -> first sample_tick 8 cycles later, then every 8 cycles.
- Nominal frame: in_valid held 1, L=100, R=-40 -> sum_out=60, diff_out=140, a single out_valid pulse 3 cycles after the handshake, in_ready high for exactly 1 cycle per frame.
- Extremes: L=131071, R=-131072 -> sum_out=-1, diff_out=262143. Then L=R=-131072 -> sum_out=-262144, diff_out=0.
- Underrun:
  - Load pair (5,3), then hold in_valid=0 across the next tick -> underrun=1, outputs repeat sum 8 / diff 2.
  - Pulse underrun_clr on the same cycle as a new underrun event -> underrun stays 1 (counter = 1 when SF192_UNDERRUN_CNT_EN is defined).
- Enable drop: deassert enable while the FSM is in SUM -> frame completes with one out_valid; no sample_tick or in_ready thereafter until enable returns.
- Reset mid-frame: assert reset while the FSM is in DIFF -> outputs zero immediately, no out_valid. After release, the next frame operates normally.
